fe_symbol_receiver: RTL and testbench
=====================================

// Module: fe_symbol_receiver
// PURPOSE
//   Receiving end of the Fe 2-bit symbol handshake. The transmitter presents {bit1,bit0} and raises Dt;
//   this block samples the symbol, answers with ack (four-phase), and packs SYMS_PER_WORD symbols into
//   one word for the local consumer. Cclear from the transmitter starts a new frame. senack reports
//   that the word has been delivered. Sits between the Fe transmitter and the local datapath, on one clock.
// PARAMETERS
//   SYMS_PER_WORD  4  symbols per word. DATA_W = 2*SYMS_PER_WORD (localparam). Legal range 1..16.
// PORTS
//   clk        in   1       sole clock, rising edge
//   reset      in   1       synchronous, active-high
//   Dt         in   1       transmitter data-valid strobe (four-phase request)
//   bit0       in   1       symbol LSB, stable while Dt=1
//   bit1       in   1       symbol MSB, stable while Dt=1
//   Cclear     in   1       transmitter frame-clear, level
//   ack        out  1       four-phase acknowledge to transmitter
//   senack     out  1       word-delivered acknowledge to transmitter
//   out_data   out  DATA_W  assembled word
//   out_valid  out  1       out_data valid
//   out_ready  in   1       consumer accepts word when out_valid & out_ready
//   proto_err  out  1       sticky: Dt seen while in S_SENT; cleared only by reset
// BEHAVIOUR
//   Reset (reset=1 at a clk edge, any state, mid-transfer included): state=S_IDLE; ack=0; senack=0;
//     out_valid=0; out_data=0; sym_cnt=0; proto_err=0. reset overrides every other input.
//   Dt_s and Cclear_s are the internal copies of Dt and Cclear (see CONFIGURATION).
//   Symbol k (0-based, in arrival order) goes to out_data[2k+1:2k] = {bit1,bit0}, so symbol 0 is the LSBs.
//   Registered outputs throughout. All outputs change only on clk.
//   FSM:
//   S_IDLE : ack=0.
//     - Cclear_s=1: clear shift register and sym_cnt; stay. Takes priority over Dt_s in the same cycle.
//       Dt_s is still high next cycle and is sampled then.
//     - else Dt_s=1: capture {bit1,bit0} at slot sym_cnt; sym_cnt+1; ack<=1; go to S_ACK.
//   S_ACK  : ack=1, held until Dt_s=0. Then ack<=0.
//     - If sym_cnt==SYMS_PER_WORD: out_data<=word; out_valid<=1; sym_cnt<=0; go to S_OUT.
//     - else go to S_IDLE.
//     - Cclear_s is ignored in S_ACK.
//   S_OUT  : out_valid=1, out_data stable.
//     - Dt_s is not acknowledged here (backpressure to transmitter).
//     - On out_valid&out_ready: out_valid<=0; senack<=1; go to S_SENT.
//     - Cclear_s is ignored in S_OUT.
//   S_SENT : senack=1.
//     - Cclear_s=1: senack<=0; clear shift register; go to S_IDLE.
//     - Dt_s=1 without Cclear_s: proto_err<=1. Dt_s is not acked.
//   Latency:
//     - Dt_s high to ack high: 1 clk.
//     - Dt_s low to ack low: 1 clk.
//     - Final ack low to out_valid: same edge.
//     - Handshake to senack: 1 clk.
//   sym_cnt width is $clog2(SYMS_PER_WORD+1). It never exceeds SYMS_PER_WORD and has no wrap-around.
// CONFIGURATION
//   FE_RX_SYNC_EN defined:
//     - Dt and Cclear each pass through a 2-flop synchronizer (reset to 0) to give Dt_s and Cclear_s.
//     - Adds 2 clk to every input-side latency.
//     - bit0/bit1 are sampled directly; they are stable under the four-phase rule.
//   Not defined: Dt_s=Dt and Cclear_s=Cclear, with no added latency.
// TESTING
//   1. Reset mid-S_ACK (ack=1) -> next edge: ack=0, out_valid=0, sym_cnt=0. A fresh 4-symbol frame then
//      works normally.
//   2. Symbols 2'b01,2'b10,2'b11,2'b00, each a full Dt/ack four-phase cycle, out_ready=1 ->
//      out_data=8'h39 for 1 clk, then senack=1.
//   3. Hold out_ready=0 for 10 clk after the word completes; transmitter raises Dt -> ack stays 0,
//      out_data stable. Raise out_ready -> senack=1. Cclear -> senack=0; the pending Dt is acked next clk.
//   4. Cclear and Dt rise on the same edge in S_IDLE with 1 symbol already held -> sym_cnt cleared first,
//      the new symbol lands in out_data[1:0], ack rises 1 clk later.
//   5. Dt raised in S_SENT with no Cclear -> proto_err=1 and stays 1 until reset; ack stays 0.
//   6. Rerun test 2 with FE_RX_SYNC_EN defined -> identical out_data=8'h39; each ack edge lags its Dt edge
//      by 3 clk instead of 1.

Source files
------------

// File: rtl/fe_symbol_receiver.sv
// rtl/fe_symbol_receiver.sv - Fe 2-bit symbol receiver: four-phase ack, word packing, senack.
// Optional FE_RX_SYNC_EN: 2-flop synchronizers on Dt and Cclear.
`timescale 1ns/1ps
module fe_symbol_receiver #(
   parameter  int SYMS_PER_WORD = 4,
   localparam int DATA_W        = 2 * SYMS_PER_WORD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Dt,
   input  logic              bit0,
   input  logic              bit1,
   input  logic              Cclear,
   output logic              ack,
   output logic              senack,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              proto_err
);
   localparam int CW = $clog2(SYMS_PER_WORD + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_OUT, S_SENT} state_t;

   logic dt_s;
   logic cclear_s;

`ifdef FE_RX_SYNC_EN
   logic [1:0] dt_sync;
   logic [1:0] cclear_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         dt_sync     <= '0;
         cclear_sync <= '0;
      end else begin
         dt_sync     <= {dt_sync[0], Dt};
         cclear_sync <= {cclear_sync[0], Cclear};
      end
   end

   assign dt_s     = dt_sync[1];
   assign cclear_s = cclear_sync[1];
`else
   assign dt_s     = Dt;
   assign cclear_s = Cclear;
`endif

   state_t            state, state_n;
   logic [CW-1:0]     sym_cnt, sym_cnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DATA_W-1:0] out_data_n;
   logic              ack_n, senack_n, out_valid_n, proto_err_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         sym_cnt   <= '0;
         shreg     <= '0;
         out_data  <= '0;
         ack       <= 1'b0;
         senack    <= 1'b0;
         out_valid <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_n;
         sym_cnt   <= sym_cnt_n;
         shreg     <= shreg_n;
         out_data  <= out_data_n;
         ack       <= ack_n;
         senack    <= senack_n;
         out_valid <= out_valid_n;
         proto_err <= proto_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      sym_cnt_n   = sym_cnt;
      shreg_n     = shreg;
      out_data_n  = out_data;
      ack_n       = ack;
      senack_n    = senack;
      out_valid_n = out_valid;
      proto_err_n = proto_err;
      case (state)
         S_IDLE: begin
            // Frame clear wins; a simultaneous Dt stays high and is taken next cycle.
            if (cclear_s) begin
               shreg_n   = '0;
               sym_cnt_n = '0;
            end else if (dt_s) begin
               for (int k = 0; k < SYMS_PER_WORD; k++) begin
                  if (sym_cnt == CW'(k)) shreg_n[2*k +: 2] = {bit1, bit0};
               end
               sym_cnt_n = sym_cnt + CW'(1);
               ack_n     = 1'b1;
               state_n   = S_ACK;
            end
         end
         S_ACK: begin
            if (!dt_s) begin
               ack_n = 1'b0;
               if (sym_cnt == CW'(SYMS_PER_WORD)) begin
                  out_data_n  = shreg;
                  out_valid_n = 1'b1;
                  sym_cnt_n   = '0;
                  state_n     = S_OUT;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               senack_n    = 1'b1;
               state_n     = S_SENT;
            end
         end
         S_SENT: begin
            if (cclear_s) begin
               senack_n = 1'b0;
               shreg_n  = '0;
               state_n  = S_IDLE;
            end else if (dt_s) begin
               proto_err_n = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fe_symbol_receiver.sv
// tb/tb_fe_symbol_receiver.sv - randomized self-checking bench for fe_symbol_receiver.
`timescale 1ns/1ps
module tb_fe_symbol_receiver;
   localparam int SPW = 4;
   localparam int DW  = 2 * SPW;
`ifdef FE_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset, Dt, bit0, bit1, Cclear, out_ready;
   logic          ack, senack, out_valid, proto_err;
   logic [DW-1:0] out_data;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: the word is just the arrival-ordered symbols packed LSB first.
   logic [DW-1:0] exp_word;
   int            nsym;

   fe_symbol_receiver #(.SYMS_PER_WORD(SPW)) dut (
      .clk(clk), .reset(reset), .Dt(Dt), .bit0(bit0), .bit1(bit1), .Cclear(Cclear),
      .ack(ack), .senack(senack), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_word = '0;
      nsym     = 0;
   endtask

   task automatic model_add(input logic [1:0] s);
      exp_word[2*nsym +: 2] = s;
      nsym++;
   endtask

   function automatic logic sig(input int sel);
      return (sel == 0) ? ack : senack;
   endfunction

   // Steps until the chosen output reaches val; n is the cycle count (bounded).
   task automatic wait_sig(input int sel, input logic val, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (sig(sel) !== val && n < 40);
   endtask

   task automatic fall_phase();
      int n;
      Dt = 1'b0;
      wait_sig(0, 1'b0, n);
      chk_eq("ack_fall_lat", 32'(n), 32'(LAT));
      if (nsym == SPW) begin
         chk_eq("word_valid", 32'(out_valid), 32'd1);
         chk_eq("word_data", 32'(out_data), 32'(exp_word));
      end else begin
         chk_eq("no_valid_midframe", 32'(out_valid), 32'd0);
      end
   endtask

   task automatic send_sym(input logic [1:0] s, input bit clr);
      int n;
      bit1 = s[1];
      bit0 = s[0];
      Dt   = 1'b1;
      if (clr) begin
         Cclear = 1'b1;
         step();
         Cclear = 1'b0;
         model_clear();
      end
      wait_sig(0, 1'b1, n);
      chk_eq(clr ? "ack_rise_lat_clr" : "ack_rise_lat", 32'(n), 32'(LAT));
      model_add(s);
      fall_phase();
   endtask

   task automatic deliver(input int stall);
      logic [DW-1:0] held;
      held      = out_data;
      out_ready = 1'b0;
      repeat (stall) begin
         step();
         chk_eq("stall_valid", 32'(out_valid), 32'd1);
         chk_eq("stall_data", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      step();
      chk_eq("hs_valid_low", 32'(out_valid), 32'd0);
      chk_eq("hs_senack", 32'(senack), 32'd1);
      out_ready = 1'b0;
      model_clear();
   endtask

   task automatic clear_frame();
      int n;
      Cclear = 1'b1;
      wait_sig(1, 1'b0, n);
      chk_eq("senack_clr_lat", 32'(n), 32'(LAT));
      Cclear = 1'b0;
      step();
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < SPW; i++) begin
         repeat ($urandom_range(0, max_gap)) step();
         send_sym(2'($urandom_range(0, 3)), 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]    s;
      logic [DW-1:0] held;
      int            n;

      reset = 1'b1; Dt = 1'b0; bit0 = 1'b0; bit1 = 1'b0; Cclear = 1'b0; out_ready = 1'b0;
      model_clear();
      repeat (3) step();
      chk_eq("rst_ack", 32'(ack), 32'd0);
      chk_eq("rst_senack", 32'(senack), 32'd0);
      chk_eq("rst_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_data", 32'(out_data), 32'd0);
      chk_eq("rst_proto_err", 32'(proto_err), 32'd0);
      reset = 1'b0;
      step();

      // Directed frame 01,10,11,00
      send_sym(2'b01, 1'b0);
      send_sym(2'b10, 1'b0);
      send_sym(2'b11, 1'b0);
      send_sym(2'b00, 1'b0);
      chk_eq("frame39", 32'(out_data), 32'h39);
      deliver(0);
      clear_frame();
      chk_eq("no_proto_err", 32'(proto_err), 32'd0);

      // Random frames with random gaps and consumer stalls
      for (int f = 0; f < 8; f++) begin
         send_frame(2);
         deliver($urandom_range(0, 5));
         clear_frame();
      end
      chk_eq("no_proto_err_rand", 32'(proto_err), 32'd0);

      // Backpressure with Dt pending during S_OUT
      send_frame(1);
      s    = 2'($urandom_range(0, 3));
      bit1 = s[1];
      bit0 = s[0];
      Dt   = 1'b1;
      held = out_data;
      repeat (10) begin
         step();
         chk_eq("bp_ack", 32'(ack), 32'd0);
         chk_eq("bp_valid", 32'(out_valid), 32'd1);
         chk_eq("bp_data", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      step();
      chk_eq("bp_senack", 32'(senack), 32'd1);
      out_ready = 1'b0;
      step();
      chk_eq("bp_proto_err", 32'(proto_err), 32'd1);
      chk_eq("bp_sent_ack", 32'(ack), 32'd0);
      Cclear = 1'b1;
      wait_sig(1, 1'b0, n);
      chk_eq("bp_senack_clr_lat", 32'(n), 32'(LAT));
      Cclear = 1'b0;
      model_clear();
      wait_sig(0, 1'b1, n);
      chk_eq("bp_pending_ack_lat", 32'(n), 32'(LAT));
      model_add(s);
      fall_phase();

      // One symbol held; Cclear and Dt rise together -> frame restarts with the new symbol
      send_sym(2'($urandom_range(0, 3)), 1'b1);
      for (int i = 1; i < SPW; i++) send_sym(2'($urandom_range(0, 3)), 1'b0);
      deliver(1);
      clear_frame();
      chk_eq("proto_err_sticky", 32'(proto_err), 32'd1);

      // Reset in the middle of an ack
      bit1 = 1'b1; bit0 = 1'b1; Dt = 1'b1;
      wait_sig(0, 1'b1, n);
      chk_eq("pre_rst_ack", 32'(ack), 32'd1);
      reset = 1'b1;
      Dt    = 1'b0;
      step();
      chk_eq("midrst_ack", 32'(ack), 32'd0);
      chk_eq("midrst_valid", 32'(out_valid), 32'd0);
      chk_eq("midrst_senack", 32'(senack), 32'd0);
      chk_eq("midrst_proto_err", 32'(proto_err), 32'd0);
      reset = 1'b0;
      model_clear();
      step();
      send_frame(0);
      deliver(0);

      // Dt in S_SENT without Cclear
      s    = 2'($urandom_range(0, 3));
      bit1 = s[1];
      bit0 = s[0];
      Dt   = 1'b1;
      repeat (6) begin
         step();
         chk_eq("sent_dt_ack", 32'(ack), 32'd0);
         chk_eq("sent_dt_senack", 32'(senack), 32'd1);
      end
      chk_eq("sent_dt_proto_err", 32'(proto_err), 32'd1);
      Dt = 1'b0;
      step();
      clear_frame();
      chk_eq("proto_err_hold", 32'(proto_err), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_eq("proto_err_reset", 32'(proto_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
